mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu.sv | 31 +++
 rtl/mul_sequencer.sv | 148 ++++++++++++++
 tb/tb_mul_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multiply sequencer and the external ALU.
// Holds the ALU opcode constants and the sequencer's FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage : alu_pkg

// File: rtl/alu.sv
// Shared combinational ALU. The sequencer borrows it for its add and
// shift steps; any other requester would be multiplexed in front of it.
//   alu_srca, alu_srcb : operands
//   alu_operation      : opcode (ALU_ADD, ALU_SLL, ALU_AND)
//   alu_result         : result, same cycle
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    alu_srca,
    input  logic [DATA_WIDTH-1:0]    alu_srcb,
    input  logic [OPCODE_LENGTH-1:0] alu_operation,
    output logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    always_comb begin
        // NOTE: default assignment first so no path leaves alu_result unassigned (no latch).
        alu_result = '0;
        case (alu_operation)
            OPCODE_LENGTH'(ALU_ADD): alu_result = alu_srca + alu_srcb;
            OPCODE_LENGTH'(ALU_SLL): alu_result = alu_srca << alu_srcb[SHAMT_W-1:0];
            OPCODE_LENGTH'(ALU_AND): alu_result = alu_srca & alu_srcb;
            default:                 alu_result = '0;
        endcase
    end

endmodule : alu

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier that borrows an external shared ALU.
// Each multiplier bit costs two granted ALU cycles: an ADD that folds the
// current multiplicand into the accumulator (kept only if the bit is set)
// and an SLL that doubles the multiplicand. Iteration stops as soon as no
// set bits remain in the multiplier.
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid/in_ready       : request handshake, op_a x op_b
//   out_valid/out_ready     : result handshake, product (low DATA_WIDTH bits)
//   busy                    : sequencer not idle
//   alu_req/alu_gnt         : shared ALU request / grant
//   alu_srca/srcb/operation : ALU operands and opcode, alu_result returned
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    product,
    output logic                     busy,
    output logic                     alu_req,
    input  logic                     alu_gnt,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    seq_state_t               r_state;
    logic [DATA_WIDTH-1:0]    r_acc;
    logic [DATA_WIDTH-1:0]    r_mcand;
    logic [DATA_WIDTH-1:0]    r_mplier;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;
    logic                     r_alu_req;
    logic [OPCODE_LENGTH-1:0] r_alu_op;
    logic [DATA_WIDTH-1:0]    w_mplier_next;
    logic [DATA_WIDTH-1:0]    w_srca;
    logic [DATA_WIDTH-1:0]    w_srcb;

    assign w_mplier_next = r_mplier >> 1;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_alu_req   <= 1'b0;
            r_alu_op    <= OPCODE_LENGTH'(ALU_AND);
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc      <= '0;
                        r_mcand    <= op_a;
                        r_mplier   <= op_b;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (op_b != '0) begin
                            r_state   <= ADD;
                            r_alu_req <= 1'b1;
                            r_alu_op  <= OPCODE_LENGTH'(ALU_ADD);
                        end else begin
                            // Zero multiplier: product is already known.
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ADD: begin
                    if (alu_gnt) begin
                        if (r_mplier[0]) begin
                            r_acc <= alu_result;
                        end
                        r_state  <= SHIFT;
                        r_alu_op <= OPCODE_LENGTH'(ALU_SLL);
                    end
                end
                SHIFT: begin
                    if (alu_gnt) begin
                        r_mcand  <= alu_result;
                        r_mplier <= w_mplier_next;
                        // Early exit once the remaining multiplier bits are all zero.
                        if (w_mplier_next == '0) begin
                            r_state     <= DONE;
                            r_alu_req   <= 1'b0;
                            r_alu_op    <= OPCODE_LENGTH'(ALU_AND);
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state  <= ADD;
                            r_alu_op <= OPCODE_LENGTH'(ALU_ADD);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand muxing follows the registered state, so operands stay put
    // for as long as a grant is withheld.
    always_comb begin
        w_srca = '0;
        w_srcb = '0;
        case (r_state)
            ADD: begin
                w_srca = r_acc;
                w_srcb = r_mcand;
            end
            SHIFT: begin
                w_srca = r_mcand;
                w_srcb = DATA_WIDTH'(1);
            end
            default: ;
        endcase
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign busy          = r_busy;
    assign alu_req       = r_alu_req;
    assign alu_operation = r_alu_op;
    assign alu_srca      = w_srca;
    assign alu_srcb      = w_srcb;
    assign product       = r_acc;

endmodule : mul_sequencer

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer with the shared ALU attached.
// A transaction-level model (operands, expected product, count of granted
// ALU cycles still owed) predicts every handshake flag and ALU operand on
// each cycle; directed cases pin the model with hand-computed values.
module tb_mul_sequencer;

    localparam int         DW     = 32;
    localparam int         OW     = 4;
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam int         BUDGET = 800;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic          alu_req, alu_gnt;
    logic [DW-1:0] op_a, op_b, product;
    logic [DW-1:0] alu_srca, alu_srcb, alu_result;
    logic [OW-1:0] alu_operation;

    int n_checks = 0;
    int n_errors = 0;

    mul_sequencer #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy),
        .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_operation(alu_operation), .alu_result(alu_result)
    );

    alu #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) u_alu (
        .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_operation(alu_operation), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Granted ALU cycles needed: two per bit up to the highest set bit.
    function automatic int latency(input logic [DW-1:0] b);
        int k = -1;
        for (int i = 0; i < DW; i++) if (b[i]) k = i;
        return (k < 0) ? 0 : 2 * (k + 1);
    endfunction

    // ---------------- transaction-level model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} m_phase_t;
    m_phase_t      m_phase = M_IDLE;
    logic [DW-1:0] m_a = '0, m_b = '0, m_prod = '0;
    int            m_total = 0;
    int            m_step  = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= M_IDLE;
            m_step  <= 0;
        end else begin
            case (m_phase)
                M_IDLE: if (in_valid) begin
                    m_a     <= op_a;
                    m_b     <= op_b;
                    m_prod  <= DW'(op_a * op_b);
                    m_total <= latency(op_b);
                    m_step  <= 0;
                    m_phase <= (op_b == '0) ? M_DONE : M_RUN;
                end
                M_RUN: if (alu_gnt) begin
                    m_step <= m_step + 1;
                    if (m_step + 1 == m_total) m_phase <= M_DONE;
                end
                M_DONE: if (out_ready) m_phase <= M_IDLE;
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Per-cycle compare: iteration i starts with acc = a * (b mod 2^i) and
    // multiplicand = a << i; even steps are adds, odd steps are shifts.
    logic [DW-1:0] e_acc, e_mcand, e_mask;
    int            e_it;
    always @(negedge clk) begin
        check("in_ready",  in_ready,  m_phase == M_IDLE);
        check("busy",      busy,      m_phase != M_IDLE);
        check("out_valid", out_valid, m_phase == M_DONE);
        check("alu_req",   alu_req,   m_phase == M_RUN);
        if (m_phase == M_DONE) check("product", product, m_prod);
        if (m_phase == M_RUN) begin
            e_it    = m_step / 2;
            e_mask  = (DW'(1) << e_it) - DW'(1);
            e_acc   = DW'(m_a * (m_b & e_mask));
            e_mcand = m_a << e_it;
            if ((m_step % 2) == 0) begin
                check("add_op",   alu_operation, OP_ADD);
                check("add_srca", alu_srca, e_acc);
                check("add_srcb", alu_srcb, e_mcand);
            end else begin
                check("sll_op",   alu_operation, OP_SLL);
                check("sll_srca", alu_srca, e_mcand);
                check("sll_srcb", alu_srcb, 1);
            end
        end else begin
            check("idle_op",   alu_operation, OP_NOP);
            check("idle_srca", alu_srca, 0);
            check("idle_srcb", alu_srcb, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_reset();
        @(posedge clk); #2;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    // Issues one multiply from IDLE; returns granted ALU cycles, cycles until
    // out_valid, cycles with alu_req seen, and the delivered product.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int gnt_pct, input int hold, input bit noise,
                          output int granted, output int cycles, output int reqs,
                          output logic [DW-1:0] prod);
        bit done = 0;
        op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        granted = 0; cycles = 0; reqs = 0; prod = '0;
        while (!done) begin
            alu_gnt = ($urandom_range(99) < gnt_pct);
            if (noise) begin
                in_valid = 1'($urandom_range(1));
                op_a = $urandom; op_b = $urandom;
            end
            @(negedge clk);
            if (out_valid) begin
                done = 1;
            end else begin
                if (alu_req) reqs++;
                if (alu_req && alu_gnt) granted++;
                cycles++;
                if (cycles > BUDGET) begin
                    check("timeout", 0, 1);
                    pulse_reset();
                    return;
                end
                @(posedge clk); #2;
            end
        end
        prod = product;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            alu_gnt = 1'($urandom_range(1));
            if (noise) begin
                in_valid = 1'($urandom_range(1));
                op_a = $urandom; op_b = $urandom;
            end
            @(negedge clk);
            check("hold_valid",   out_valid, 1);
            check("hold_product", product, prod);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, c, r, n;
        logic [DW-1:0] p, a, b;
        bit found;

        in_valid = 1'b0; out_ready = 1'b0; alu_gnt = 1'b0;
        op_a = '0; op_b = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_alu_req",   alu_req,   0);
        check("rst_product",   product,   0);
        @(posedge clk); #2;
        reset = 1'b0;

        // 3 x 5 with constant grant: six cycles, held until out_ready.
        run_op(32'd3, 32'd5, 100, 3, 0, g, c, r, p);
        check("m3x5_cycles",  c, 6);
        check("m3x5_granted", g, 6);
        check("m3x5_product", p, 32'd15);

        // All-ones squared: 64 granted cycles, wraps to 1.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, 0, 0, g, c, r, p);
        check("ff_granted", g, 64);
        check("ff_product", p, 32'h0000_0001);

        // Zero multiplier: result one cycle after accept, ALU never requested.
        run_op(32'h1234_5678, 32'd0, 100, 1, 0, g, c, r, p);
        check("zero_cycles",  c, 0);
        check("zero_reqs",    r, 0);
        check("zero_product", p, 32'd0);

        // 7 x 6 with pseudo-random grants.
        run_op(32'd7, 32'd6, 50, 0, 0, g, c, r, p);
        check("m7x6_granted", g, 6);
        check("m7x6_product", p, 32'd42);

        // Result held for 10 cycles with stray requests, then released.
        run_op(32'd11, 32'd13, 100, 10, 1, g, c, r, p);
        check("hold_product_val", p, 32'd143);
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        @(posedge clk); #2;

        // Reset in the middle of a 32-iteration multiply, during a shift.
        op_a = 32'h0BAD_F00D; op_b = 32'hFFFF_FFFF; in_valid = 1'b1; alu_gnt = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        n = 0; found = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            if (alu_operation == OP_SLL && n >= 20) found = 1;
            else begin
                n++;
                @(posedge clk); #2;
            end
        end
        check("reached_shift", found, 1);
        #1 reset = 1'b1; alu_gnt = 1'b0;
        #1;
        check("midrst_in_ready",  in_ready,  1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy",      busy,      0);
        check("midrst_alu_req",   alu_req,   0);
        check("midrst_product",   product,   0);
        @(posedge clk); #2;
        reset = 1'b0;
        run_op(32'd9, 32'd9, 70, 1, 0, g, c, r, p);
        check("m9x9_product", p, 32'd81);

        // Randomized traffic against the model.
        for (int t = 0; t < 30; t++) begin
            int sh;
            a  = $urandom;
            sh = $urandom_range(32);
            b  = (sh == 32) ? '0 : ($urandom >> sh);
            run_op(a, b, $urandom_range(30, 100), $urandom_range(0, 3), 1, g, c, r, p);
            check("rnd_granted", g, latency(b));
            check("rnd_product", p, DW'(a * b));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mul_sequencer
